// File: rtl/powlib_ipdma.sv
// powlib_ipdma: single-channel bus-master copy engine with bounded outstanding reads
`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif
module powlib_ipdma #(
   parameter  int          B_BPD    = 2,
   parameter  int          B_AW     = 8*B_BPD,
   localparam int          B_DW     = 8*B_BPD,
   localparam int          B_BEW    = B_BPD,
   parameter  int          B_OPW    = `POWLIB_OPW,
   localparam int          B_WW     = B_DW+B_BEW+B_OPW,
   parameter  int          OP_WRITE = 0,
   parameter  int          OP_READ  = 1,
   parameter  int unsigned RET_ADDR = 16'hFFFF,
   parameter  int          MAXO     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [B_AW-1:0] src,
   input  logic [B_AW-1:0] dst,
   input  logic [B_AW-1:0] len,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [B_AW-1:0] wraddr,
   output logic [B_WW-1:0] wrdata,
   output logic            wrvld,
   input  logic            wrrdy,
   input  logic [B_AW-1:0] rdaddr,
   input  logic [B_WW-1:0] rddata,
   input  logic            rdvld,
   output logic            rdrdy
);
   localparam int FAW = $clog2(MAXO);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [B_AW-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [B_AW-1:0] rd_q, rd_d, wr_q, wr_d, wraddr_q, wraddr_d;
   logic [B_WW-1:0] wrdata_q, wrdata_d;
   logic            wrvld_q, wrvld_d, err_q, err_d;
   logic [B_DW-1:0] mem_q [MAXO];
   logic [FAW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [FAW:0]    cnt_q, cnt_d, fl_q, fl_d;
   logic [B_AW-1:0] rd_n, wr_n;
   logic            acc, is_rd, fin, choose, do_wr, do_rd, rsp, push, stray, start_ok;
   logic            unused_ok;
   assign unused_ok = ^{rdaddr, rddata[B_WW-1:B_DW]};
   // counters as they stand after the beat (if any) accepted this cycle
   assign acc      = wrvld_q & wrrdy;
   assign is_rd    = wrdata_q[B_DW+B_BEW+:B_OPW] == B_OPW'(OP_READ);
   assign rd_n     = rd_q + B_AW'(acc & is_rd);
   assign wr_n     = wr_q + B_AW'(acc & ~is_rd);
   assign fin      = acc & ~is_rd & (wr_n == len_q);
   // a new beat is picked only when the request register is free or being emptied
   assign choose   = (state_q == RUN) & (~wrvld_q | wrrdy) & ~fin;
   assign do_wr    = choose & (cnt_q != 0);
   assign do_rd    = choose & (cnt_q == 0) & (rd_n < len_q) & ((rd_n - wr_n) < B_AW'(MAXO));
   assign start_ok = (state_q == IDLE) & start;
   // responses with nothing in flight are swallowed and flagged
   assign rdrdy    = rst & ((state_q != RUN) | (cnt_q < (FAW+1)'(MAXO)));
   assign rsp      = rdvld & rdrdy;
   assign push     = rsp & (fl_q != 0);
   assign stray    = rsp & (fl_q == 0);
   assign busy     = state_q == RUN;
   assign done     = state_q == DONE;
   assign err      = err_q;
   assign wraddr   = wraddr_q;
   assign wrdata   = wrdata_q;
   assign wrvld    = wrvld_q;
   // next-state: control FSM, copy counters, request register and response FIFO pointers
   always_comb begin
      state_d  = state_q == IDLE ? (start ? (len == 0 ? DONE : RUN) : IDLE) :
                 state_q == RUN  ? (fin ? DONE : RUN) : IDLE;
      src_d    = start_ok ? src : src_q;
      dst_d    = start_ok ? dst : dst_q;
      len_d    = start_ok ? len : len_q;
      rd_d     = start_ok ? '0 : rd_n;
      wr_d     = start_ok ? '0 : wr_n;
      wrvld_d  = do_wr | do_rd | (wrvld_q & ~wrrdy);
      wraddr_d = do_wr ? dst_q + wr_n : do_rd ? src_q + rd_n : wraddr_q;
      wrdata_d = do_wr ? {B_OPW'(OP_WRITE), {B_BEW{1'b1}}, mem_q[rp_q]} :
                 do_rd ? {B_OPW'(OP_READ), {B_BEW{1'b1}}, B_DW'(RET_ADDR)} : wrdata_q;
      err_d    = (err_q & ~start_ok) | stray;
      wp_d     = wp_q + FAW'(push);
      rp_d     = rp_q + FAW'(do_wr);
      cnt_d    = cnt_q + (FAW+1)'(push) - (FAW+1)'(do_wr);
      fl_d     = fl_q + (FAW+1)'(acc & is_rd) - (FAW+1)'(push);
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
         wraddr_q <= '0;
         wrdata_q <= '0;
         wrvld_q  <= 1'b0;
         err_q    <= 1'b0;
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         fl_q     <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wraddr_q <= wraddr_d;
         wrdata_q <= wrdata_d;
         wrvld_q  <= wrvld_d;
         err_q    <= err_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         cnt_q    <= cnt_d;
         fl_q     <= fl_d;
      end
   end
   // response FIFO storage; validity is tracked by the pointers alone
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= rddata[B_DW-1:0];
   end
endmodule

// File: tb/tb_powlib_ipdma.sv
// tb_powlib_ipdma: table-driven and randomized copy checks against a transfer-level model
module tb_powlib_ipdma;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [15:0] src = '0, dst = '0, len = '0;
   logic        busy, done, err, wrvld, rdrdy;
   logic [15:0] wraddr, rdaddr;
   logic [19:0] wrdata, rddata;
   logic        wrrdy, rdvld;
   int checks = 0, errors = 0;

   powlib_ipdma dut (
      .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .err(err), .wraddr(wraddr), .wrdata(wrdata),
      .wrvld(wrvld), .wrrdy(wrrdy), .rdaddr(rdaddr), .rddata(rddata),
      .rdvld(rdvld), .rdrdy(rdrdy)
   );

   always #5 clk = ~clk;

   typedef struct {logic [15:0] d; int due;} rsp_t;
   typedef struct {logic [15:0] src, dst, len; int lat, pct; bit tog; logic [15:0] last_wa;} vec_t;

   rsp_t        rq[$];
   logic [15:0] src_e = '0, dst_e = '0, len_e = '0, salt = '0, lastwa = '0;
   int          lat = 2, pct = 100, cyc = 0, nr = 0, nw = 0, ndone = 0;
   bit          tog = 1'b0, stray_req = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] memfn(input logic [15:0] a);
      return 16'(a * 16'h9E37) ^ salt;
   endfunction

   // bus slave + monitor: decides inputs at the negedge and logs the beats taken at the next posedge
   initial begin
      logic        pv, pr, real_rsp;
      logic [35:0] pbeat, e;
      pv = 1'b0; pr = 1'b0; pbeat = '0;
      wrrdy = 1'b0; rdvld = 1'b0; rddata = '0; rdaddr = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            rq.delete();
            wrrdy = 1'b0; rdvld = 1'b0; pv = 1'b0;
         end else begin
            if (pv && !pr) check("hold", 64'({wraddr, wrdata}), 64'(pbeat));
            if (done) ndone++;
            wrrdy = tog ? ~wrrdy : ($urandom_range(99) < pct);
            real_rsp = rq.size() > 0 && cyc >= rq[0].due;
            if (real_rsp) begin
               rdvld = 1'b1; rddata = {2'd0, 2'b11, rq[0].d};
            end else if (stray_req) begin
               rdvld = 1'b1; rddata = {2'd0, 2'b11, 16'($urandom)};
            end else rdvld = 1'b0;
            if (wrvld && wrrdy) begin
               if (wrdata[19:18] == 2'd1) begin
                  e = {src_e + 16'(nr), 2'd1, 2'b11, 16'hFFFF};
                  check("rd_beat", 64'({wraddr, wrdata}), 64'(e));
                  rq.push_back('{memfn(wraddr), cyc + lat});
                  nr++;
                  check("outstanding", 64'((nr - nw) <= 4), 64'(1));
                  check("in_flight", 64'(rq.size() <= 4), 64'(1));
               end else begin
                  e = {dst_e + 16'(nw), 2'd0, 2'b11, memfn(src_e + 16'(nw))};
                  check("wr_beat", 64'({wraddr, wrdata}), 64'(e));
                  nw++;
                  lastwa = wraddr;
               end
            end
            if (rdvld && rdrdy) begin
               if (real_rsp) void'(rq.pop_front());
               else stray_req = 1'b0;
            end
            pv = wrvld; pr = wrrdy; pbeat = {wraddr, wrdata};
         end
      end
   end

   task automatic run_copy(input logic [15:0] s, d, l, input int lt, p, input bit tg, input logic [15:0] exp_last);
      @(negedge clk);
      src_e = s; dst_e = d; len_e = l; lat = lt; pct = p; tog = tg; salt = 16'($urandom);
      nr = 0; nw = 0; ndone = 0; lastwa = '0;
      src = s; dst = d; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_run", 64'(busy), 64'(1));
      check("err_clr", 64'(err), 64'(0));
      for (int i = 0; i < 4000 && ndone == 0; i++) @(negedge clk);
      check("done_seen", 64'(ndone != 0), 64'(1));
      repeat (3) @(negedge clk);
      check("nreads", 64'(nr), 64'(l));
      check("nwrites", 64'(nw), 64'(l));
      check("last_waddr", 64'(lastwa), 64'(exp_last));
      check("done_once", 64'(ndone), 64'(1));
      check("err_end", 64'(err), 64'(0));
      check("busy_end", 64'(busy), 64'(0));
      check("wrvld_end", 64'(wrvld), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      logic [15:0] s, d, l;
      tbl[0] = '{16'h5555, 16'hAAA9, 16'd3, 2, 100, 1'b0, 16'hAAAB};
      tbl[1] = '{16'h1000, 16'h2000, 16'd8, 10, 100, 1'b1, 16'h2007};
      tbl[2] = '{16'hFFFE, 16'hFFFF, 16'd3, 2, 100, 1'b0, 16'h0001};
      tbl[3] = '{16'h0000, 16'h0100, 16'd1, 1, 100, 1'b0, 16'h0100};
      tbl[4] = '{16'h7FFF, 16'h8000, 16'd5, 1, 30, 1'b0, 16'h8004};
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_wrvld", 64'(wrvld), 64'(0));
      check("rst_rdrdy", 64'(rdrdy), 64'(0));
      rst = 1'b1;
      @(negedge clk);
      check("idle_rdrdy", 64'(rdrdy), 64'(1));
      // zero-length copy
      nr = 0; nw = 0;
      src = 16'h5555; dst = 16'hAAA9; len = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("z_done", 64'(done), 64'(1));
      check("z_busy", 64'(busy), 64'(0));
      check("z_wrvld", 64'(wrvld), 64'(0));
      @(negedge clk);
      check("z_done_off", 64'(done), 64'(0));
      check("z_beats", 64'(nr + nw), 64'(0));
      for (int i = 0; i < 5; i++)
         run_copy(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].lat, tbl[i].pct, tbl[i].tog, tbl[i].last_wa);
      // stray response while idle
      @(negedge clk);
      stray_req = 1'b1;
      for (int i = 0; i < 100 && stray_req; i++) @(negedge clk);
      check("stray_taken", 64'(stray_req), 64'(0));
      repeat (2) @(negedge clk);
      check("stray_err", 64'(err), 64'(1));
      run_copy(16'h0010, 16'h0020, 16'd2, 3, 100, 1'b0, 16'h0021);
      // reset in the middle of a copy
      @(negedge clk);
      src_e = 16'h0300; dst_e = 16'h0400; len_e = 16'd6; lat = 3; pct = 100; tog = 1'b0;
      nr = 0; nw = 0; ndone = 0;
      src = 16'h0300; dst = 16'h0400; len = 16'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 500 && nw < 2; i++) @(negedge clk);
      check("mid_writes", 64'(nw >= 2), 64'(1));
      rst = 1'b0;
      @(negedge clk);
      check("mid_busy", 64'(busy), 64'(0));
      check("mid_wrvld", 64'(wrvld), 64'(0));
      check("mid_done", 64'(done), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      run_copy(16'h0300, 16'h0400, 16'd6, 2, 100, 1'b0, 16'h0405);
      // randomized copies
      for (int k = 0; k < 6; k++) begin
         s = 16'($urandom);
         d = 16'($urandom);
         l = 16'($urandom_range(1, 20));
         run_copy(s, d, l, $urandom_range(1, 6), $urandom_range(30, 100), 1'b0, d + l - 16'd1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
